// File: rtl/conv_engine_if.sv
// Stream bundle between the feature-map buffer, conv_engine and the
// activation stage. Inputs are plain strobed streams: a beat is transferred
// in every cycle its valid is high, there is no ready/back-pressure, and the
// producer must supply every beat of a filter or image load. out_valid marks
// a result beat; out_data is 0 whenever out_valid is low.
interface conv_engine_if #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 16
) ();
   logic              filter_valid;
   logic              filter_size;
   logic              image_valid;
   logic [3:0]        image_size;
   logic              pad_mode;
   logic              act_mode;
   logic              stride;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;

   modport master (
      output filter_valid, filter_size, image_valid, image_size,
             pad_mode, act_mode, stride, in_data,
      input  out_valid, out_data
   );

   modport slave (
      input  filter_valid, filter_size, image_valid, image_size,
             pad_mode, act_mode, stride, in_data,
      output out_valid, out_data
   );
endinterface

// File: rtl/conv_engine.sv
// Streaming 2-D convolution: loads a 3x3/5x5 filter and an NxN image as byte
// streams, then emits one saturated window result per cycle (stride 1 or 2,
// zero or replicate padding, optional ReLU). The filter persists across images.
module conv_engine #(
   parameter int DATA_W  = 8,
   parameter int OUT_W   = 16,
   parameter int MAX_IMG = 8
) (
   input  logic          clk,
   input  logic          rst_n,        // active-high asynchronous reset
   conv_engine_if.slave  bus,
   output logic [1:0]    dbg_state_o
);
   localparam int ACC_W = 2*DATA_W + 5;
   localparam int NPIX  = MAX_IMG*MAX_IMG;
   localparam int CW    = 8;            // holds up to 15*15 beats
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD_F, S_LOAD_I, S_OUT} state_e;

   state_e                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       k5_q, k5_d;
   logic [3:0]                 n_q, n_d;
   logic                       pad_q, pad_d, act_q, act_d, stride_q, stride_d;
   logic [3:0]                 r_q, r_d, c_q, c_d;
   logic signed [DATA_W-1:0]   coef_q [25];
   logic signed [DATA_W-1:0]   img_q  [NPIX];
   logic                       out_valid_q;
   logic [OUT_W-1:0]           out_data_q;

   logic                       coef_we, img_we, compute_en;
   logic [CW-1:0]              wr_idx;
   logic [3:0]                 n_in;
   logic [7:0]                 kk, nn;
   logic [4:0]                 step, c_nxt, r_nxt;
   logic signed [ACC_W-1:0]    acc;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [DATA_W-1:0]   pix;
   logic [OUT_W-1:0]           res;
   int                         rr, cc, idx, cidx, ksz, half;
   logic                       in_range;

   assign n_in = (bus.image_size < 4'd3) ? 4'd3 :
                 (bus.image_size > 4'(MAX_IMG)) ? 4'(MAX_IMG) : bus.image_size;
   assign kk   = k5_q ? 8'd25 : 8'd9;
   assign nn   = {4'b0, n_q} * {4'b0, n_q};
   assign step = stride_q ? 5'd2 : 5'd1;
   assign c_nxt = {1'b0, c_q} + step;
   assign r_nxt = {1'b0, r_q} + step;

   // Next-state, load control and output-position scan
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      k5_d       = k5_q;
      n_d        = n_q;
      pad_d      = pad_q;
      act_d      = act_q;
      stride_d   = stride_q;
      r_d        = r_q;
      c_d        = c_q;
      coef_we    = 1'b0;
      img_we     = 1'b0;
      wr_idx     = cnt_q;
      compute_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            // filter_valid has priority when both streams start together
            if (bus.filter_valid) begin
               k5_d    = bus.filter_size;
               coef_we = 1'b1;
               wr_idx  = '0;
               cnt_d   = 8'd1;
               state_d = S_LOAD_F;
            end else if (bus.image_valid) begin
               n_d      = n_in;
               pad_d    = bus.pad_mode;
               act_d    = bus.act_mode;
               stride_d = bus.stride;
               img_we   = 1'b1;
               wr_idx   = '0;
               cnt_d    = 8'd1;
               state_d  = S_LOAD_I;
            end
         end
         S_LOAD_F: begin
            if (bus.filter_valid) begin
               coef_we = 1'b1;
               if (cnt_q == kk - 8'd1) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         S_LOAD_I: begin
            if (bus.image_valid) begin
               img_we = 1'b1;
               if (cnt_q == nn - 8'd1) begin
                  cnt_d   = '0;
                  r_d     = '0;
                  c_d     = '0;
                  state_d = S_OUT;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         S_OUT: begin
            compute_en = 1'b1;
            if (c_nxt >= {1'b0, n_q}) begin
               c_d = '0;
               if (r_nxt >= {1'b0, n_q}) state_d = S_IDLE;
               else                      r_d = r_nxt[3:0];
            end else begin
               c_d = c_nxt[3:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Window sum for the current output position, then ReLU and saturation
   always_comb begin
      acc      = '0;
      prod     = '0;
      pix      = '0;
      rr       = 0;
      cc       = 0;
      idx      = 0;
      cidx     = 0;
      in_range = 1'b0;
      ksz      = k5_q ? 5 : 3;
      half     = k5_q ? 2 : 1;
      for (int ti = 0; ti < 5; ti++) begin
         for (int tj = 0; tj < 5; tj++) begin
            if (ti < ksz && tj < ksz) begin
               rr       = int'(r_q) + ti - half;
               cc       = int'(c_q) + tj - half;
               in_range = (rr >= 0) && (rr < int'(n_q)) && (cc >= 0) && (cc < int'(n_q));
               // replicate mode clamps to the nearest edge pixel
               if (rr < 0)           rr = 0;
               if (rr >= int'(n_q))  rr = int'(n_q) - 1;
               if (cc < 0)           cc = 0;
               if (cc >= int'(n_q))  cc = int'(n_q) - 1;
               idx  = rr*int'(n_q) + cc;
               cidx = ti*ksz + tj;
               pix  = (in_range || pad_q) ? img_q[idx[CW-1:0]] : '0;
               prod = $signed({{DATA_W{coef_q[cidx[4:0]][DATA_W-1]}}, coef_q[cidx[4:0]]}) *
                      $signed({{DATA_W{pix[DATA_W-1]}}, pix});
               acc  = acc + {{5{prod[2*DATA_W-1]}}, prod};
            end
         end
      end
      if (act_q && acc[ACC_W-1]) acc = '0;
      if (acc > SAT_MAX)      res = SAT_MAX[OUT_W-1:0];
      else if (acc < SAT_MIN) res = SAT_MIN[OUT_W-1:0];
      else                    res = acc[OUT_W-1:0];
   end

   // Control registers and filter storage; reset clears the filter to zeros, K=3
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         k5_q     <= 1'b0;
         n_q      <= 4'd3;
         pad_q    <= 1'b0;
         act_q    <= 1'b0;
         stride_q <= 1'b0;
         r_q      <= '0;
         c_q      <= '0;
         for (int i = 0; i < 25; i++) coef_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         k5_q     <= k5_d;
         n_q      <= n_d;
         pad_q    <= pad_d;
         act_q    <= act_d;
         stride_q <= stride_d;
         r_q      <= r_d;
         c_q      <= c_d;
         if (coef_we) coef_q[wr_idx[4:0]] <= bus.in_data;
      end
   end

   // Image buffer, row-major at stride N; contents need no reset
   always_ff @(posedge clk) begin
      if (img_we) img_q[wr_idx] <= bus.in_data;
   end

   // Registered result stage; data forced to 0 outside valid beats
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= compute_en;
         out_data_q  <= compute_en ? res : '0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_conv_engine.sv
// Directed/random bench for conv_engine: a reference model pushes expected
// results when an image is driven; they are popped as out_valid beats arrive.
module tb_conv_engine;
   localparam int DATA_W  = 8;
   localparam int OUT_W   = 16;
   localparam int MAX_IMG = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;

   conv_engine_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

   conv_engine #(.DATA_W(DATA_W), .OUT_W(OUT_W), .MAX_IMG(MAX_IMG)) dut (
      .clk         (clk),
      .rst_n       (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   int               checks = 0;
   int               errors = 0;
   logic [OUT_W-1:0] exp_q[$];
   int               filt_m[25];
   int               k_m = 3;
   int               img_m[225];
   int               n_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference convolution over img_m/filt_m; pushes every expected result
   task automatic model(input int n, input bit pad, input bit act, input bit strd, output int cnt);
      int     step;
      int     half;
      longint mx;
      longint mn;
      step = strd ? 2 : 1;
      half = (k_m - 1) / 2;
      mx   = (64'sd1 <<< (OUT_W-1)) - 1;
      mn   = -(64'sd1 <<< (OUT_W-1));
      cnt  = 0;
      for (int r = 0; r < n; r += step) begin
         for (int c = 0; c < n; c += step) begin
            longint acc;
            acc = 0;
            for (int i = 0; i < k_m; i++) begin
               for (int j = 0; j < k_m; j++) begin
                  int rr;
                  int cc;
                  int p;
                  rr = r + i - half;
                  cc = c + j - half;
                  if (rr < 0 || rr >= n || cc < 0 || cc >= n) begin
                     if (!pad) p = 0;
                     else begin
                        if (rr < 0) rr = 0;
                        if (rr >= n) rr = n - 1;
                        if (cc < 0) cc = 0;
                        if (cc >= n) cc = n - 1;
                        p = img_m[rr*n + cc];
                     end
                  end else begin
                     p = img_m[rr*n + cc];
                  end
                  acc += longint'(filt_m[i*k_m + j]) * longint'(p);
               end
            end
            if (act && acc < 0) acc = 0;
            if (acc > mx) acc = mx;
            if (acc < mn) acc = mn;
            exp_q.push_back(acc[OUT_W-1:0]);
            cnt++;
         end
      end
   endtask

   task automatic idle_inputs();
      bus.filter_valid = 1'b0;
      bus.filter_size  = 1'b0;
      bus.image_valid  = 1'b0;
      bus.image_size   = 4'd0;
      bus.pad_mode     = 1'b0;
      bus.act_mode     = 1'b0;
      bus.stride       = 1'b0;
      bus.in_data      = '0;
   endtask

   // Drive filt_m as a filter load; later beats carry junk filter_size,
   // optionally with image_valid held high to show it is ignored
   task automatic load_filter(input bit k5, input bit also_img);
      int k;
      k = k5 ? 5 : 3;
      for (int i = 0; i < k*k; i++) begin
         bus.filter_valid = 1'b1;
         bus.filter_size  = (i == 0) ? k5 : 1'($urandom_range(0, 1));
         bus.in_data      = filt_m[i][DATA_W-1:0];
         if (also_img) begin
            bus.image_valid = 1'b1;
            bus.image_size  = 4'($urandom_range(0, 15));
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      k_m = k;
   endtask

   // Drive img_m as an image; configuration changes after beat 0 are junk
   task automatic send_image(input int size, input bit pad, input bit act, input bit strd,
                             output int cnt);
      int n;
      n = (size < 3) ? 3 : (size > MAX_IMG) ? MAX_IMG : size;
      model(n, pad, act, strd, cnt);
      for (int i = 0; i < n*n; i++) begin
         bus.image_valid = 1'b1;
         bus.in_data     = img_m[i][DATA_W-1:0];
         if (i == 0) begin
            bus.image_size = 4'(size);
            bus.pad_mode   = pad;
            bus.act_mode   = act;
            bus.stride     = strd;
         end else begin
            bus.image_size = 4'($urandom_range(0, 15));
            bus.pad_mode   = 1'($urandom_range(0, 1));
            bus.act_mode   = 1'($urandom_range(0, 1));
            bus.stride     = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   // Called right after the last pixel edge (T): out_valid must be low now,
   // high with the expected data for cnt consecutive cycles from T+2, then low.
   // abort_at >= 0 applies a one-cycle reset while that output is visible.
   task automatic collect(input int cnt, input int abort_at);
      logic [OUT_W-1:0] e;
      chk("no_early_valid", 32'(bus.out_valid), 32'd0);
      for (int i = 0; i < cnt; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
            e = '0;
         end else begin
            e = exp_q.pop_front();
         end
         chk("out_valid", 32'(bus.out_valid), 32'd1);
         chk($sformatf("out_data[%0d]", i), 32'(bus.out_data), 32'(e));
         if (i == abort_at) begin
            rst = 1'b1;
            #1;
            chk("rst_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_data", 32'(bus.out_data), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(posedge clk); #1;
               chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
               chk("post_rst_data", 32'(bus.out_data), 32'd0);
               chk("post_rst_state", 32'(dbg_state), 32'd0);
            end
            exp_q.delete();
            for (int j = 0; j < 25; j++) filt_m[j] = 0;
            k_m = 3;
            return;
         end
      end
      @(posedge clk); #1;
      chk("valid_drop", 32'(bus.out_valid), 32'd0);
      chk("data_zero", 32'(bus.out_data), 32'd0);
      chk("back_to_idle", 32'(dbg_state), 32'd0);
   endtask

   initial begin
      idle_inputs();
      // reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_data", 32'(bus.out_data), 32'd0);
      chk("reset_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // ones filter, 4x4 ones image: zero pad, replicate, then reuse filter
      for (int i = 0; i < 9; i++) filt_m[i] = 1;
      load_filter(1'b0, 1'b0);
      chk("idle_after_filter", 32'(dbg_state), 32'd0);
      for (int i = 0; i < 16; i++) img_m[i] = 1;
      send_image(4, 1'b0, 1'b0, 1'b0, n_out);
      collect(n_out, -1);
      send_image(4, 1'b1, 1'b0, 1'b0, n_out);
      collect(n_out, -1);
      send_image(4, 1'b1, 1'b0, 1'b0, n_out);
      collect(n_out, -1);

      // -1 filter on 5s: identity then ReLU
      for (int i = 0; i < 9; i++) filt_m[i] = -1;
      load_filter(1'b0, 1'b0);
      for (int i = 0; i < 9; i++) img_m[i] = 5;
      send_image(3, 1'b0, 1'b0, 1'b0, n_out);
      collect(n_out, -1);
      send_image(3, 1'b0, 1'b1, 1'b0, n_out);
      collect(n_out, -1);

      // saturation both ways with 5x5 filters
      for (int i = 0; i < 25; i++) filt_m[i] = -128;
      load_filter(1'b1, 1'b0);
      for (int i = 0; i < 25; i++) img_m[i] = -128;
      send_image(5, 1'b1, 1'b0, 1'b0, n_out);
      collect(n_out, -1);
      for (int i = 0; i < 25; i++) filt_m[i] = 127;
      load_filter(1'b1, 1'b0);
      send_image(5, 1'b1, 1'b0, 1'b0, n_out);
      collect(n_out, -1);

      // centre-only filter loaded with image_valid also high, then stride 2
      for (int i = 0; i < 9; i++) filt_m[i] = (i == 4) ? 1 : 0;
      load_filter(1'b0, 1'b1);
      chk("img_ignored_in_filter", 32'(dbg_state), 32'd0);
      for (int i = 0; i < 25; i++) img_m[i] = i;
      send_image(5, 1'b0, 1'b0, 1'b1, n_out);
      chk("stride2_count", 32'(exp_q.size()), 32'd9);
      collect(n_out, -1);

      // random 5x5 filter, 7x7 image, replicate + ReLU; then size 2 clamps to 3
      for (int i = 0; i < 25; i++) filt_m[i] = int'($urandom_range(0, 255)) - 128;
      load_filter(1'b1, 1'b0);
      for (int i = 0; i < 49; i++) img_m[i] = int'($urandom_range(0, 255)) - 128;
      send_image(7, 1'b1, 1'b1, 1'b0, n_out);
      collect(n_out, -1);
      for (int i = 0; i < 9; i++) img_m[i] = int'($urandom_range(0, 255)) - 128;
      send_image(2, 1'b0, 1'b0, 1'b0, n_out);
      collect(n_out, -1);
      send_image(6, 1'b1, 1'b0, 1'b1, n_out);
      collect(n_out, -1);

      // reset at the 5th output, then an image sees the cleared filter
      for (int i = 0; i < 9; i++) filt_m[i] = int'($urandom_range(1, 20));
      load_filter(1'b0, 1'b0);
      for (int i = 0; i < 16; i++) img_m[i] = int'($urandom_range(1, 100));
      send_image(4, 1'b0, 1'b0, 1'b0, n_out);
      collect(n_out, 4);
      send_image(4, 1'b1, 1'b0, 1'b0, n_out);
      collect(n_out, -1);

      // oversize image_size clamps to MAX_IMG: 64 pixels in, 64 results out
      for (int i = 0; i < 9; i++) filt_m[i] = int'($urandom_range(0, 255)) - 128;
      load_filter(1'b0, 1'b0);
      for (int i = 0; i < 64; i++) img_m[i] = int'($urandom_range(0, 255)) - 128;
      send_image(15, 1'b1, 1'b0, 1'b0, n_out);
      chk("clamp_count", 32'(exp_q.size()), 32'd64);
      collect(n_out, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv_engine.md
# conv_engine

Parametrised streaming 2-D convolution engine and successor to the fixed 8-bit convolution block. It loads a square filter of size 3x3 or 5x5 and a square image of size 3..MAX_IMG as serial byte streams, then emits the padded ("same") or stride-2 decimated convolution map serially. It adds replicate padding, stride 2, parametrised data and output widths, and saturating accumulation. It sits between the feature-map input buffer and the activation/pooling stage.

## Interface
- DATA_W, 8: width of signed filter coefficients and pixels
- OUT_W, 16: signed output width; the result saturates to this range
- MAX_IMG, 8: largest image side, legal range 3..15
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-high despite the name; asserted (1) clears all state
- filter_valid  in  1  high for exactly K*K consecutive cycles while coefficients stream in
- filter_size  in  1  sampled on the first filter_valid cycle: 0 selects K=3, 1 selects K=5
- image_valid  in  1  high for exactly N*N consecutive cycles while pixels stream in
- image_size  in  4  image side N, sampled on the first image_valid cycle
- pad_mode  in  1  sampled on the first image_valid cycle: 0 zero padding, 1 replicate (edge clamp)
- act_mode  in  1  sampled on the first image_valid cycle: 0 identity, 1 ReLU
- stride  in  1  sampled on the first image_valid cycle: 0 stride 1, 1 stride 2
- in_data  in  DATA_W  signed coefficient or pixel, row-major
- out_valid  out  1  output strobe
- out_data  out  OUT_W  signed result; 0 whenever out_valid is 0

## Operation
- States and transitions:
  - IDLE → LOAD_F on filter_valid.
  - IDLE → LOAD_I on image_valid.
  - LOAD_F → IDLE after K*K coefficients.
  - LOAD_I → OUT after N*N pixels.
  - OUT → IDLE after the last output.
- The filter is retained across images and can be reused by any number of images without reloading. Reset clears the filter to all zeros and K to 3.
- Effective image side: N = min(max(image_size, 3), MAX_IMG).
- Image buffer holds MAX_IMG*MAX_IMG pixels, written row-major.
- Output positions, scanned row-major:
  - stride 1: every (r,c) with 0 ≤ r,c < N, giving N*N outputs.
  - stride 2: (2i,2j) with 2i,2j < N, giving ceil(N/2)^2 outputs.
- Window: centred on (r,c), offsets -(K-1)/2..(K-1)/2.
  - Out-of-range taps read 0 in zero-pad mode.
  - Out-of-range taps read the nearest edge pixel (clamped row and column) in replicate mode.
- Arithmetic:
  - Each product is a full 2*DATA_W signed value.
  - Accumulation is 2*DATA_W+5 bits, which never overflows for 25 taps.
  - ReLU is applied if act_mode=1.
  - The result then saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Protocol violations:
  - filter_valid or image_valid asserted in OUT is ignored entirely.
  - If filter_valid and image_valid are both high in IDLE, filter_valid wins and image_valid is ignored for the whole filter load.
  - A filter_valid or image_valid pulse that drops early leaves the block waiting in LOAD_F/LOAD_I for the remaining beats; there is no timeout.
  - image_valid in LOAD_F is ignored.
  - filter_valid in LOAD_I is ignored.

## Timing
- Reset values: out_valid=0, out_data=0, state IDLE, all counters 0, filter zeroed.
- Reset mid-operation aborts immediately. The first post-reset transfer starts clean, with no residual output.
- Configuration inputs are sampled only on the first valid beat; changes during a stream have no effect.
- Let T be the cycle in which the last pixel is sampled:
  - OUT computes one window per cycle, starting at T+1.
  - Results are registered, so out_valid is high continuously from T+2 for exactly the output count.
  - There are no bubbles.
- After the last out_valid cycle, the block is in IDLE and accepts filter_valid or image_valid on the very next cycle.
- A new filter or image may begin in the cycle after LOAD_F completes; the coefficients are already in use for that image.

## Test plan
- Ones 3x3 filter, 4x4 all-1 image, zero pad, stride 1 → 16 outputs starting T+2:
  - corners 4
  - edges 6
  - interior 9
- Same stimulus with replicate pad → all 16 outputs equal 9. Then a second image with no filter reload → the same 16 outputs, proving filter retention.
- 3x3 filter all -1, 3x3 image all 5:
  - act_mode 0 → centre output -45
  - act_mode 1 → all 9 outputs 0
- 5x5 filter all -128, 5x5 image all -128, replicate pad, OUT_W=16 → every output saturates to 32767. With filter all 127 and image all -128 → every output -32768.
- Stride 2, N=5 (image values 0..24 row-major), 3x3 centre-only filter (coefficient 1 at tap 4) → 9 outputs 0,2,4,10,12,14,20,22,24 on 9 consecutive cycles.
- Reset mid-operation:
  - Assert rst_n for one cycle at the 5th out_valid of a 16-output run → out_valid and out_data are 0 from reset onward.
  - A subsequent image with no filter load → all outputs 0, because the filter was cleared.
  - image_size=15 with MAX_IMG=8 → exactly 64 pixels are accepted and 64 outputs are produced.
